mmio_timer_pwm: RTL and testbench

//  Parametrised memory-mapped peripheral block: NUM_PWM PWM channels with PWM_BITS resolution,
//  and free-running micros/millis timers derived from CLK_HZ.

---
 rtl/mmio_timer_pwm.sv | 212 +++++++++++++++++++++
 tb/tb_mmio_timer_pwm.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_timer_pwm.sv
// -----------------------------------------------------------------------------
// mmio_timer_pwm
//   Memory-mapped timer/PWM peripheral on the shared CPU read/write bus.
//   Provides free-running MICROS/MILLIS counters derived from CLK_HZ, a MICROS
//   compare-match interrupt, and NUM_PWM double-buffered PWM channels with a
//   global enable.
//
//   Register window (BASE_ADDR .. BASE_ADDR+63, word offsets):
//     0x00 CTRL    RW   [0] irq_en, [1] pwm_en
//     0x04 STATUS  RW1C [0] pend
//     0x08 MICROS  RO
//     0x0C MILLIS  RO
//     0x10 CMP     RW   32 bit
//     0x20+4*i DUTY[i] RW shadow duty, low PWM_BITS bits
//
// Ports
//   clk            system clock
//   rst            asynchronous active-high reset
//   write_mem      write strobe
//   funct3         access size: [1] word, [0] half, otherwise byte
//   write_address  write byte address
//   write_data     right-aligned write data
//   read_address   read byte address
//   read_data      registered aligned register word (0 outside the window)
//   read_hit       registered: previous read_address was inside the window
//   pwm_out        registered active-high PWM outputs
//   irq            level interrupt, STATUS.pend & CTRL.irq_en
// -----------------------------------------------------------------------------
module mmio_timer_pwm #(
    parameter int          NUM_PWM   = 4,
    parameter int          PWM_BITS  = 8,
    parameter int          CLK_HZ    = 12_000_000,
    parameter logic [31:0] BASE_ADDR = 32'hFFFFFF00
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               write_mem,
    input  logic [2:0]         funct3,
    input  logic [31:0]        write_address,
    input  logic [31:0]        write_data,
    input  logic [31:0]        read_address,
    output logic [31:0]        read_data,
    output logic               read_hit,
    output logic [NUM_PWM-1:0] pwm_out,
    output logic               irq
);

    localparam int PRESC   = CLK_HZ / 1_000_000;
    localparam int PRESC_W = $clog2(PRESC);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC - 1);

    // ---------------------------------------------------------------- state
    logic [1:0]          ctrl_q,   ctrl_d;
    logic                pend_q,   pend_d;
    logic [31:0]         micros_q, micros_d;
    logic [31:0]         millis_q, millis_d;
    logic [31:0]         cmp_q,    cmp_d;
    logic [PRESC_W-1:0]  presc_q,  presc_d;
    logic [9:0]          sub_q,    sub_d;
    logic [PWM_BITS-1:0] cnt_q,    cnt_d;
    logic [PWM_BITS-1:0] shadow_q [NUM_PWM];
    logic [PWM_BITS-1:0] shadow_d [NUM_PWM];
    logic [PWM_BITS-1:0] active_q [NUM_PWM];
    logic [PWM_BITS-1:0] active_d [NUM_PWM];
    logic [NUM_PWM-1:0]  pwm_q,    pwm_d;
    logic [31:0]         read_data_q, read_data_d;
    logic                read_hit_q,  read_hit_d;

    // ------------------------------------------------------- write decode
    logic        wr_sel;
    logic [3:0]  wr_idx;
    logic [3:0]  wr_be;
    logic [31:0] wr_data_rep;
    logic [31:0] wr_mask;
    logic [31:0] wr_old;
    logic [31:0] wr_new;
    logic [31:0] reg_file [16];
    logic        rd_sel;

    assign wr_sel = write_mem && (write_address[31:6] == BASE_ADDR[31:6]);
    assign wr_idx = write_address[5:2];
    assign rd_sel = (read_address[31:6] == BASE_ADDR[31:6]);

    // Narrow data is replicated across all lanes so the byte-enable mask
    // alone picks the addressed lane(s).
    always_comb begin
        wr_be       = 4'b0000;
        wr_data_rep = write_data;
        if (funct3[1]) begin
            wr_be       = 4'b1111;
        end else if (funct3[0]) begin
            wr_be       = write_address[1] ? 4'b1100 : 4'b0011;
            wr_data_rep = {2{write_data[15:0]}};
        end else begin
            wr_be       = 4'b0001 << write_address[1:0];
            wr_data_rep = {4{write_data[7:0]}};
        end
        for (int b = 0; b < 4; b++) begin
            wr_mask[8*b +: 8] = {8{wr_be[b]}};
        end
    end

    // Every readable word in one table; shared by the read port and by the
    // read-modify-write lane merge of partial writes.
    always_comb begin
        for (int k = 0; k < 16; k++) begin
            reg_file[k] = 32'h0;
        end
        reg_file[0] = {30'h0, ctrl_q};
        reg_file[1] = {31'h0, pend_q};
        reg_file[2] = micros_q;
        reg_file[3] = millis_q;
        reg_file[4] = cmp_q;
        for (int k = 0; k < NUM_PWM; k++) begin
            reg_file[8 + k] = 32'(shadow_q[k]);
        end
    end

    assign wr_old = reg_file[wr_idx];
    assign wr_new = (wr_old & ~wr_mask) | (wr_data_rep & wr_mask);

    // ------------------------------------------------------ timers / regs
    logic us_tick;
    logic ms_tick;
    logic cmp_match;
    logic w1c;
    logic cnt_wrap;

    always_comb begin
        us_tick   = (presc_q == PRESC_LAST);
        ms_tick   = us_tick && (sub_q == 10'd999);
        presc_d   = us_tick ? '0 : presc_q + 1'b1;
        micros_d  = micros_q + 32'(us_tick);
        millis_d  = millis_q + 32'(ms_tick);
        sub_d     = ms_tick ? 10'd0 : (us_tick ? sub_q + 10'd1 : sub_q);

        // Edge-triggered: only an increment landing on CMP raises pend, so
        // loading CMP with the current MICROS value never does.
        cmp_match = us_tick && ((micros_q + 32'd1) == cmp_q);
        w1c       = wr_sel && (wr_idx == 4'd1) && wr_be[0] && wr_data_rep[0];
        pend_d    = cmp_match | (pend_q & ~w1c);

        ctrl_d    = (wr_sel && (wr_idx == 4'd0)) ? wr_new[1:0] : ctrl_q;
        cmp_d     = (wr_sel && (wr_idx == 4'd4)) ? wr_new : cmp_q;

        cnt_d     = cnt_q + 1'b1;
        cnt_wrap  = &cnt_q;

        read_hit_d  = rd_sel;
        read_data_d = rd_sel ? reg_file[read_address[5:2]] : 32'h0;
    end

    // ------------------------------------------------------- PWM channels
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PWM; gi++) begin : gen_ch
            assign shadow_d[gi] = (wr_sel && (wr_idx == 4'(8 + gi)))
                                  ? wr_new[PWM_BITS-1:0] : shadow_q[gi];
            // Shadow moves to active only as the counter rolls to 0, so a
            // period is never cut short or stretched by a mid-period write.
            assign active_d[gi] = cnt_wrap ? shadow_q[gi] : active_q[gi];
            assign pwm_d[gi]    = ctrl_q[1] & (cnt_q < active_q[gi]);
        end
    endgenerate

    // ------------------------------------------------------------ registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q      <= '0;
            pend_q      <= 1'b0;
            micros_q    <= '0;
            millis_q    <= '0;
            cmp_q       <= '0;
            presc_q     <= '0;
            sub_q       <= '0;
            cnt_q       <= '0;
            pwm_q       <= '0;
            read_data_q <= '0;
            read_hit_q  <= 1'b0;
            for (int k = 0; k < NUM_PWM; k++) begin
                shadow_q[k] <= '0;
                active_q[k] <= '0;
            end
        end else begin
            ctrl_q      <= ctrl_d;
            pend_q      <= pend_d;
            micros_q    <= micros_d;
            millis_q    <= millis_d;
            cmp_q       <= cmp_d;
            presc_q     <= presc_d;
            sub_q       <= sub_d;
            cnt_q       <= cnt_d;
            pwm_q       <= pwm_d;
            read_data_q <= read_data_d;
            read_hit_q  <= read_hit_d;
            for (int k = 0; k < NUM_PWM; k++) begin
                shadow_q[k] <= shadow_d[k];
                active_q[k] <= active_d[k];
            end
        end
    end

    assign read_data = read_data_q;
    assign read_hit  = read_hit_q;
    assign pwm_out   = pwm_q;
    assign irq       = pend_q & ctrl_q[0];

    // Sub-word read offsets and funct3[2] carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{funct3[2], read_address[1:0]};

endmodule

// File: tb/tb_mmio_timer_pwm.sv
// -----------------------------------------------------------------------------
// tb_mmio_timer_pwm
//   Self-checking bench for mmio_timer_pwm. A behavioural model (closed-form
//   timers, per-period duty table) predicts reads, pwm_out and irq. Reads push
//   their expectation into a queue at issue time; a monitor pops and compares
//   when the registered result appears.
// -----------------------------------------------------------------------------
module tb_mmio_timer_pwm;

    localparam int          NUM_PWM  = 4;
    localparam int          PWM_BITS = 8;
    localparam int          CLK_HZ   = 12_000_000;
    localparam logic [31:0] BASE     = 32'hFFFFFF00;
    localparam longint      P        = CLK_HZ / 1_000_000;
    localparam longint      PERIOD   = longint'(1) << PWM_BITS;
    localparam logic [31:0] DUTY_MASK = (32'd1 << PWM_BITS) - 32'd1;
    localparam logic [2:0]  F_WORD = 3'b010;
    localparam logic [2:0]  F_HALF = 3'b001;
    localparam logic [2:0]  F_BYTE = 3'b000;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               write_mem = 1'b0;
    logic [2:0]         funct3 = 3'b0;
    logic [31:0]        write_address = 32'h0;
    logic [31:0]        write_data = 32'h0;
    logic [31:0]        read_address = 32'h0;
    logic [31:0]        read_data;
    logic               read_hit;
    logic [NUM_PWM-1:0] pwm_out;
    logic               irq;
    logic               rd_req = 1'b0;

    mmio_timer_pwm #(
        .NUM_PWM  (NUM_PWM),
        .PWM_BITS (PWM_BITS),
        .CLK_HZ   (CLK_HZ),
        .BASE_ADDR(BASE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .write_mem    (write_mem),
        .funct3       (funct3),
        .write_address(write_address),
        .write_data   (write_data),
        .read_address (read_address),
        .read_data    (read_data),
        .read_hit     (read_hit),
        .pwm_out      (pwm_out),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // ------------------------------------------------------------ model
    typedef struct {
        logic        hit;
        logic [31:0] data;
        string       nm;
    } exp_t;
    exp_t rd_q[$];

    longint              m_n;          // clock edges since reset release
    logic [1:0]          m_ctrl;
    logic [31:0]         m_cmp;
    logic                m_pend;
    logic [31:0]         m_shadow [NUM_PWM];
    logic [PWM_BITS-1:0] m_active [NUM_PWM];
    logic [NUM_PWM-1:0]  m_pwm;
    logic                rd_pipe;

    function automatic logic in_win(input logic [31:0] a);
        return a[31:6] == BASE[31:6];
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] a,
                                          input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        r = old;
        if (f3[1]) r = d;
        else if (f3[0]) begin
            if (a[1]) r[31:16] = d[15:0];
            else      r[15:0]  = d[15:0];
        end else begin
            case (a[1:0])
                2'd0: r[7:0]   = d[7:0];
                2'd1: r[15:8]  = d[7:0];
                2'd2: r[23:16] = d[7:0];
                default: r[31:24] = d[7:0];
            endcase
        end
        return r;
    endfunction

    function automatic logic [31:0] cur_merge(input logic [31:0] old);
        return merge(old, write_address, funct3, write_data);
    endfunction

    function automatic logic cur_w1c();
        logic [31:0] lanes;
        lanes = merge(32'h0, write_address, funct3, write_data);
        return write_mem && in_win(write_address) && (write_address[5:2] == 4'd1) && lanes[0];
    endfunction

    function automatic logic cur_wr(input int idx);
        return write_mem && in_win(write_address) && (int'(write_address[5:2]) == idx);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int idx;
        if (!in_win(a)) return 32'h0;
        idx = int'(a[5:2]);
        case (idx)
            0: return {30'h0, m_ctrl};
            1: return {31'h0, m_pend};
            2: return 32'(m_n / P);
            3: return 32'(m_n / (P * 1000));
            4: return m_cmp;
            default: begin
                if (idx >= 8 && idx < 8 + NUM_PWM) return m_shadow[idx-8];
                return 32'h0;
            end
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_n <= 0; m_ctrl <= 2'b0; m_cmp <= 32'h0; m_pend <= 1'b0;
            m_pwm <= '0; rd_pipe <= 1'b0;
            for (int i = 0; i < NUM_PWM; i++) begin
                m_shadow[i] <= 32'h0;
                m_active[i] <= '0;
            end
        end else begin
            // MICROS lands on a new value every P edges; pend follows that
            m_pend <= (((m_n + 1) % P == 0) && (32'((m_n + 1) / P) == m_cmp))
                      | (m_pend & !cur_w1c());
            for (int i = 0; i < NUM_PWM; i++) begin
                m_pwm[i] <= m_ctrl[1] && ((m_n % PERIOD) < longint'(m_active[i]));
                if ((m_n + 1) % PERIOD == 0) m_active[i] <= m_shadow[i][PWM_BITS-1:0];
                if (cur_wr(8 + i)) m_shadow[i] <= cur_merge(m_shadow[i]) & DUTY_MASK;
            end
            if (cur_wr(0)) m_ctrl <= 2'(cur_merge({30'h0, m_ctrl}));
            if (cur_wr(4)) m_cmp  <= cur_merge(m_cmp);
            m_n     <= m_n + 1;
            rd_pipe <= rd_req;
        end
    end

    // ---------------------------------------------------------- monitor
    always @(negedge clk) begin
        if (!rst) begin
            chk("pwm_out", 32'(pwm_out), 32'(m_pwm));
            chk("irq", 32'(irq), 32'(m_pend & m_ctrl[0]));
            if (rd_pipe) begin
                if (rd_q.size() == 0) begin
                    chk("read_queue_underflow", 32'(read_hit), 32'h0);
                end else begin
                    exp_t e;
                    e = rd_q.pop_front();
                    chk({e.nm, " data"}, read_data, e.data);
                    chk({e.nm, " hit"}, 32'(read_hit), 32'(e.hit));
                end
            end
        end
    end

    // ----------------------------------------------------------- driver
    task automatic bus(input logic wr, input logic [31:0] wa, input logic [2:0] f3,
                       input logic [31:0] wd, input logic rd, input logic [31:0] ra,
                       input logic use_k, input logic [31:0] k, input string nm);
        exp_t e;
        write_mem     = wr;
        write_address = wa;
        funct3        = f3;
        write_data    = wd;
        rd_req        = rd;
        read_address  = rd ? ra : 32'h0;
        if (rd) begin
            e.hit  = in_win(ra);
            e.data = use_k ? k : model_read(ra);
            e.nm   = nm;
            rd_q.push_back(e);
            $display("txn rd  addr=%h exp=%h (%s)", ra, e.data, nm);
        end
        if (wr) $display("txn wr  addr=%h f3=%0d data=%h", wa, f3, wd);
        @(posedge clk);
        #1;
        write_mem    = 1'b0;
        rd_req       = 1'b0;
        read_address = 32'h0;
    endtask

    task automatic idle();
        bus(1'b0, 32'h0, F_WORD, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, "");
    endtask

    task automatic wr(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
        bus(1'b1, a, f3, d, 1'b0, 32'h0, 1'b0, 32'h0, "");
    endtask

    task automatic rd_k(input logic [31:0] a, input logic [31:0] k, input string nm);
        bus(1'b0, 32'h0, F_WORD, 32'h0, 1'b1, a, 1'b1, k, nm);
    endtask

    task automatic do_reset();
        idle();
        idle();
        #2 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        rd_q.delete();
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] idx;
        case ($urandom_range(0, 10))
            0: idx = 0;  1: idx = 1;  2: idx = 2;  3: idx = 3;
            4: idx = 4;  5: idx = 5;  6: idx = 8;  7: idx = 9;
            8: idx = 10; 9: idx = 11; default: idx = 15;
        endcase
        if ($urandom_range(0, 9) == 0) return BASE - 32'd64 + idx * 4;
        return BASE + idx * 4;
    endfunction

    // -------------------------------------------------------- stimulus
    initial begin
        int cnt;
        #1 rst = 1'b1;
        #2;
        chk("reset read_data", read_data, 32'h0);
        chk("reset read_hit", 32'(read_hit), 32'h0);
        chk("reset pwm_out", 32'(pwm_out), 32'h0);
        chk("reset irq", 32'(irq), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // every offset reads zero after reset; below-window read misses
        for (int off = 0; off < 64; off += 4) rd_k(BASE + 32'(off), 32'h0, "reset_offset");
        rd_k(BASE - 32'd4, 32'h0, "below_window");

        // timer rates
        do_reset();
        repeat (11) idle();
        rd_k(BASE + 32'h08, 32'd0, "micros_n11");
        rd_k(BASE + 32'h08, 32'd1, "micros_n12");
        while (m_n < 11999) idle();
        rd_k(BASE + 32'h0C, 32'd0,    "millis_n11999");
        rd_k(BASE + 32'h0C, 32'd1,    "millis_n12000");
        rd_k(BASE + 32'h08, 32'd1000, "micros_n12001");

        // partial writes
        wr(BASE + 32'h20, F_WORD, 32'h12);
        wr(BASE + 32'h21, F_BYTE, 32'hAB);
        rd_k(BASE + 32'h20, 32'h0000AB12 & DUTY_MASK, "sb_lane1");
        wr(BASE + 32'h20, F_BYTE, 32'h5A);
        rd_k(BASE + 32'h20, 32'h0000005A, "sb_lane0");
        wr(BASE + 32'h10, F_WORD, 32'h11223344);
        wr(BASE + 32'h12, F_HALF, 32'h0000BEEF);
        rd_k(BASE + 32'h10, 32'hBEEF3344, "sh_cmp_upper");
        // read and write of the same register in one cycle returns old value
        bus(1'b1, BASE + 32'h10, F_WORD, 32'hCAFE0000, 1'b1, BASE + 32'h10, 1'b1,
            32'hBEEF3344, "rd_during_wr");
        rd_k(BASE + 32'h10, 32'hCAFE0000, "after_wr");

        // mid-period duty update on channel 1
        wr(BASE + 32'h00, F_WORD, 32'h2);
        repeat (40) idle();
        wr(BASE + 32'h24, F_WORD, 32'h40);
        for (int k = 0; k < 600 && m_active[1] != 8'h40; k++) idle();
        chk("duty1_activated", 32'(m_active[1]), 32'h40);
        idle();
        cnt = 0;
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            cnt += int'(pwm_out[1]);
        end
        chk("pwm1_high_count", 32'(cnt), 32'd64);
        @(posedge clk);
        #1;

        // compare match interrupt
        wr(BASE + 32'h00, F_WORD, 32'h3);
        wr(BASE + 32'h10, F_WORD, 32'(m_n / P) + 32'd5);
        for (int k = 0; k < 200 && irq !== 1'b1; k++) idle();
        chk("irq_rise", 32'(irq), 32'h1);
        wr(BASE + 32'h04, F_WORD, 32'h1);
        chk("irq_w1c", 32'(irq), 32'h0);
        // W1C landing on the same edge as a new match keeps pend set
        wr(BASE + 32'h10, F_WORD, 32'(m_n / P) + 32'd3);
        for (int k = 0; k < 100; k++) begin
            if (((m_n + 1) % P == 0) && (32'((m_n + 1) / P) == m_cmp)) break;
            idle();
        end
        wr(BASE + 32'h04, F_WORD, 32'h1);
        chk("set_beats_w1c", 32'(irq), 32'h1);
        wr(BASE + 32'h04, F_WORD, 32'h1);
        chk("irq_w1c_again", 32'(irq), 32'h0);
        // CMP written to the present MICROS value does not set pend
        while ((m_n + 1) % P == 0) idle();
        wr(BASE + 32'h10, F_WORD, 32'(m_n / P));
        repeat (30) idle();
        chk("cmp_eq_now_no_pend", 32'(irq), 32'h0);

        // async reset while outputs are active
        wr(BASE + 32'h20, F_WORD, 32'hFF);
        wr(BASE + 32'h10, F_WORD, 32'(m_n / P) + 32'd3);
        for (int k = 0; k < 600 && !(pwm_out[0] === 1'b1 && irq === 1'b1); k++) idle();
        chk("pre_reset_active", {30'h0, pwm_out[0], irq}, 32'h3);
        #2 rst = 1'b1;
        #1;
        chk("async_rst pwm_out", 32'(pwm_out), 32'h0);
        chk("async_rst irq", 32'(irq), 32'h0);
        chk("async_rst read_hit", 32'(read_hit), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        rd_q.delete();
        repeat (11) idle();
        rd_k(BASE + 32'h08, 32'd0, "restart_micros_n11");
        rd_k(BASE + 32'h08, 32'd1, "restart_micros_n12");
        rd_k(BASE + 32'h20, 32'd0, "restart_duty0");

        // randomized traffic against the model
        for (int t = 0; t < 1500; t++) begin
            logic        dw;
            logic        dr;
            logic [31:0] wa;
            logic [31:0] wd;
            logic [31:0] ra;
            logic [2:0]  f3;
            dw = ($urandom_range(0, 2) == 0);
            wa = rand_addr();
            wd = $urandom();
            case ($urandom_range(0, 2))
                0: f3 = F_WORD;
                1: begin f3 = F_HALF; wa[1] = 1'($urandom_range(0, 1)); end
                default: begin f3 = F_BYTE; wa[1:0] = 2'($urandom_range(0, 3)); end
            endcase
            if ($urandom_range(0, 7) == 0) begin
                wa = BASE + 32'h10;
                f3 = F_WORD;
                wd = 32'(m_n / P) + 32'($urandom_range(1, 4));
            end
            dr = 1'($urandom_range(0, 1));
            ra = rand_addr();
            ra[1:0] = 2'($urandom_range(0, 3));
            bus(dw, wa, f3, wd, dr, ra, 1'b0, 32'h0, "rand_read");
        end

        repeat (3) idle();
        chk("read_queue_drained", 32'(rd_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
